// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               isdiv_q, isdiv_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic               dz_q, dz_d;
   // mult: acc = running product, aux = shifted multiplicand, mplr = remaining multiplier
   // div:  acc = partial remainder, aux = divisor, mplr = dividend shifting into quotient
   logic [2*WIDTH-1:0] acc_q, acc_d, aux_q, aux_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, divzero_q, divzero_d;

   logic               sa_in, sb_in, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] sum, prod;
   logic [WIDTH:0]     shifted, diff;

   assign sa_in   = ~op[0] & a[WIDTH-1];
   assign sb_in   = ~op[0] & b[WIDTH-1];
   assign mag_a   = sa_in ? -a : a;
   assign mag_b   = sb_in ? -b : b;
   assign b_zero  = (b == '0);
   assign sum     = acc_q + aux_q;
   assign shifted = {acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, aux_q[WIDTH-1:0]};
   assign prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      isdiv_d   = isdiv_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dz_d      = dz_q;
      acc_d     = acc_q;
      aux_d     = aux_q;
      mplr_d    = mplr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      divzero_d = divzero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               isdiv_d = op[1];
               sa_d    = sa_in;
               sb_d    = sb_in;
               dz_d    = op[1] & b_zero;
               cnt_d   = CW'(WIDTH);
               acc_d   = '0;
               state_d = S_CALC;
               if (op[1]) begin
                  mplr_d = b_zero ? a : mag_a;
                  aux_d  = {{WIDTH{1'b0}}, mag_b};
                  if (b_zero) state_d = S_FIX;
               end else begin
                  mplr_d = mag_b;
                  aux_d  = {{WIDTH{1'b0}}, mag_a};
`ifdef MULDIV_EARLY_TERM_EN
                  if (b_zero) state_d = S_FIX;
`endif
               end
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - 1'b1;
            if (isdiv_q) begin
               // restoring step: keep the difference only when it did not go negative
               acc_d  = {{(WIDTH-1){1'b0}}, diff[WIDTH] ? shifted : diff};
               mplr_d = {mplr_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
               acc_d  = mplr_q[0] ? sum : acc_q;
               aux_d  = aux_q << 1;
               mplr_d = mplr_q >> 1;
            end
            if (cnt_q == CW'(1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
            if (!isdiv_q && mplr_d == '0) state_d = S_FIX;
`endif
         end
         S_FIX: begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            done_d    = 1'b1;
            divzero_d = dz_q;
            if (!isdiv_q) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (dz_q) begin
               hi_d = mplr_q;
               lo_d = '1;
            end else begin
               lo_d = (sa_q ^ sb_q) ? -mplr_q : mplr_q;
               hi_d = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         isdiv_q   <= 1'b0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         dz_q      <= 1'b0;
         acc_q     <= '0;
         aux_q     <= '0;
         mplr_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isdiv_q   <= isdiv_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         dz_q      <= dz_d;
         acc_q     <= acc_d;
         aux_q     <= aux_d;
         mplr_q    <= mplr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign divzero = divzero_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table plus randomized checks of muldiv_unit against a plain-arithmetic reference.
module tb_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, start, mthi, mtlo;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wdata;
   logic          busy, done, divzero;
   logic [W-1:0]  hi, lo;

   int vecs = 0;
   int errs = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
      .divzero(divzero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      logic         dz;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: result from wide arithmetic, latency from the operation rules.
   task automatic ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                            output logic rdz, output int lat);
      logic signed [63:0] sx, sy, p, q, r;
      logic [63:0] up;
      logic [W-1:0] my;
      sx = {{32{x[W-1]}}, x};
      sy = {{32{y[W-1]}}, y};
      rdz = 1'b0;
      lat = W + 2;
      case (o)
         2'b00: begin p = sx * sy; rhi = p[63:32]; rlo = p[31:0]; end
         2'b01: begin up = {32'b0, x} * {32'b0, y}; rhi = up[63:32]; rlo = up[31:0]; end
         default: begin
            if (y == 0) begin
               rhi = x; rlo = '1; rdz = 1'b1; lat = 2;
            end else if (o == 2'b10) begin
               q = sx / sy; r = sx % sy; rhi = r[31:0]; rlo = q[31:0];
            end else begin
               rhi = x % y; rlo = x / y;
            end
         end
      endcase
`ifdef MULDIV_EARLY_TERM_EN
      if (!o[1]) begin
         my = (o == 2'b00 && y[W-1]) ? -y : y;
         lat = 2 + $clog2({1'b0, my} + 33'd1);
      end
`endif
   endtask

   // Issue one op; returns edges from issue until done is seen (-1 on timeout).
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin lat = k; break; end
      end
   endtask

   task automatic run_check(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y);
      logic [W-1:0] ehi, elo;
      logic edz;
      int elat, lat;
      ref_model(o, x, y, ehi, elo, edz, elat);
      issue(o, x, y, lat);
      chk({nm, ".lat"}, 64'(lat), 64'(elat));
      chk({nm, ".hi"}, 64'(hi), 64'(ehi));
      chk({nm, ".lo"}, 64'(lo), 64'(elo));
      chk({nm, ".dz"}, 64'(divzero), 64'(edz));
      chk({nm, ".busy"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk({nm, ".pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      vec_t tbl[$];
      int lat, seen;
      logic [W-1:0] ra, rb;
      logic [1:0] ro;

      reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = '0; a = '0; b = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.dz", 64'(divzero), 64'd0);
      chk("rst.hi", 64'(hi), 64'd0);
      chk("rst.lo", 64'(lo), 64'd0);
      @(negedge clk); reset = 1'b1;

      // Expected values written from the arithmetic directly.
      tbl.push_back('{2'b01, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0});
      tbl.push_back('{2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
      tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
      tbl.push_back('{2'b11, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0});
      tbl.push_back('{2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1});
      tbl.push_back('{2'b01, 32'h5, 32'h1, 32'h0, 32'h5, 1'b0});
      tbl.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0});
      tbl.push_back('{2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0});
      tbl.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0});
      tbl.push_back('{2'b10, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1});
      tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
      for (int i = 0; i < tbl.size(); i++) begin
         int elat;
         logic [W-1:0] ehi, elo;
         logic edz;
         ref_model(tbl[i].op, tbl[i].a, tbl[i].b, ehi, elo, edz, elat);
         issue(tbl[i].op, tbl[i].a, tbl[i].b, lat);
         chk($sformatf("tbl%0d.lat", i), 64'(lat), 64'(elat));
         chk($sformatf("tbl%0d.hi", i), 64'(hi), 64'(tbl[i].hi));
         chk($sformatf("tbl%0d.lo", i), 64'(lo), 64'(tbl[i].lo));
         chk($sformatf("tbl%0d.dz", i), 64'(divzero), 64'(tbl[i].dz));
      end
      // last table entry was a MULT after a div-by-zero: divzero must be cleared
      chk("dz_clear", 64'(divzero), 64'd0);

      // start and mthi while busy are ignored; mtlo after done lands next cycle
      @(negedge clk);
      op = 2'b00; a = 32'h3; b = 32'h4; start = 1'b1;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         start = 1'b0; mthi = 1'b0;
         if (k == 10) begin
            start = 1'b1; op = 2'b11; a = 32'h99; b = 32'h3; mthi = 1'b1; wdata = 32'h5;
         end
         if (done) begin lat = k; break; end
      end
      start = 1'b0; mthi = 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
      chk("busy_ign.lat", 64'(lat), 64'd5);
`else
      chk("busy_ign.lat", 64'(lat), 64'(W + 2));
`endif
      chk("busy_ign.hi", 64'(hi), 64'd0);
      chk("busy_ign.lo", 64'(lo), 64'd12);
      @(posedge clk); #1;
      chk("busy_ign.idle", 64'(busy), 64'd0);
      @(negedge clk); mtlo = 1'b1; wdata = 32'h9;
      @(posedge clk); #1; mtlo = 1'b0;
      chk("mtlo.lo", 64'(lo), 64'd9);
      chk("mtlo.hi", 64'(hi), 64'd0);

      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAA;
      @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
      chk("mtboth.hi", 64'(hi), 64'hAA);
      chk("mtboth.lo", 64'(lo), 64'hAA);

      // start beats a simultaneous move
      @(negedge clk);
      op = 2'b01; a = 32'h2; b = 32'h3; start = 1'b1; mthi = 1'b1; wdata = 32'h77;
      @(posedge clk); #1; start = 1'b0; mthi = 1'b0;
      chk("start_win.busy", 64'(busy), 64'd1);
      chk("start_win.hi_stable", 64'(hi), 64'hAA);
      lat = -1;
      for (int k = 2; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
      chk("start_win.done", 64'(lat > 0), 64'd1);
      chk("start_win.hi", 64'(hi), 64'd0);
      chk("start_win.lo", 64'(lo), 64'd6);

      // reset in the middle of a DIV discards it
      @(negedge clk);
      op = 2'b10; a = 32'h64; b = 32'h7; start = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1; start = 1'b0;
      end
      chk("mid_rst.busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst.busy", 64'(busy), 64'd0);
      chk("mid_rst.hi", 64'(hi), 64'd0);
      chk("mid_rst.lo", 64'(lo), 64'd0);
      @(negedge clk); reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("mid_rst.no_done", 64'(seen), 64'd0);

      // random operations against the reference
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'($urandom_range(1, 255));
            2: rb = -32'($urandom_range(1, 255));
            default: rb = $urandom;
         endcase
         run_check($sformatf("rnd%0d", i), ro, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
